// File: rtl/image_ram_hub_pkg.sv
// Shared definitions for the image RAM hub.
//   - FSM state encoding of the host sequencer
//   - default bank count and engine priority order
//   - bank-select values (controller RAM-select encoding)
//   - small helpers for comparing 3-bit selects against bank indices
package image_ram_hub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SERVE    = 3'd2,
    ST_DUMP_RD  = 3'd3,
    ST_DUMP_OUT = 3'd4
  } state_t;

  localparam int NUM_BANKS_DEF = 5;

  // Engine slots; a lower index wins a same-bank collision.
  localparam int NUM_ENG = 4;
  localparam int ENG_FWD = 0;
  localparam int ENG_BWD = 1;
  localparam int ENG_THR = 2;
  localparam int ENG_CNV = 3;

  // Bank-select encoding shared with the engine controller.
  localparam logic [2:0] SEL_BANK0 = 3'd0;
  localparam logic [2:0] SEL_BANK1 = 3'd1;
  localparam logic [2:0] SEL_BANK2 = 3'd2;
  localparam logic [2:0] SEL_BANK3 = 3'd3;
  localparam logic [2:0] SEL_BANK4 = 3'd4;
  localparam logic [2:0] SEL_NONE  = 3'd7;

  // True when a select addresses bank number idx.
  function automatic logic sel_is(input logic [2:0] sel, input int idx);
    return ({29'd0, sel} == idx);
  endfunction

  // True when a select addresses an existing bank.
  function automatic logic sel_in_range(input logic [2:0] sel, input int num_banks);
    return (int'({29'd0, sel}) < num_banks);
  endfunction

endpackage

// File: rtl/image_ram_hub_ram_bank.sv
// ram_bank: single-port synchronous RAM, 2^ADDR_W x DATA_W.
// One write and one read per cycle on a shared address; a read in the same
// cycle as a write returns the word as it was before the write.
// Ports:
//   clk      rising-edge clock
//   i_we     write enable (i_wdata -> mem[i_addr])
//   i_re     read enable  (mem[i_addr] -> o_rdata, registered)
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  read data; holds its value until the next read
module ram_bank #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Contents are intentionally not reset; the read register samples the
  // old word because both updates are non-blocking on the same edge.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_addr];
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/image_ram_hub.sv
// image_ram_hub: memory-side responder for the forward, backward, threshold
// and convolution engines plus a host load/dump stream.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   {f,b,t,c}_addr/rd/wr    engine requests, {f,b,c}_wdata bytes, t_wdata 1 bit
//   {f,b,t,c}_sel           engine bank select (>= NUM_BANKS: no bank)
//   {f,b,t,c}_rdata         engine read data (0 outside SERVE)
//   conflict                sticky same-bank collision flag
//   start_load/serve/dump   single-cycle commands, cmd_bank for load/dump
//   serve_end               ends SERVE
//   load_valid/data/ready   host load stream
//   dump_valid/data/ready   host dump stream
//   busy, op_done           sequencer busy, end-of-operation pulse
//   o_dbg_state             current sequencer state
//
// Stream handshakes: a word moves on a rising edge where valid and ready are
// both high. The producer keeps valid and data stable until that edge; ready
// may change freely. load_ready is high for the whole LOAD state; dump_valid
// is high for the whole DUMP_OUT state with dump_data held.
module image_ram_hub
  import image_ram_hub_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int NUM_BANKS = NUM_BANKS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [ADDR_W-1:0] t_addr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              f_rd,
  input  logic              b_rd,
  input  logic              t_rd,
  input  logic              c_rd,
  input  logic              f_wr,
  input  logic              b_wr,
  input  logic              t_wr,
  input  logic              c_wr,
  input  logic [DATA_W-1:0] f_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              t_wdata,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [2:0]        f_sel,
  input  logic [2:0]        b_sel,
  input  logic [2:0]        t_sel,
  input  logic [2:0]        c_sel,
  output logic [DATA_W-1:0] f_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] t_rdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              conflict,
  input  logic              start_load,
  input  logic              start_serve,
  input  logic              start_dump,
  input  logic [2:0]        cmd_bank,
  input  logic              serve_end,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  input  logic              dump_ready,
  output logic              busy,
  output logic              op_done,
  output logic [2:0]        o_dbg_state
);

  state_t            r_state;
  state_t            w_next;
  logic              w_op_end;
  logic [ADDR_W-1:0] r_cnt;
  logic [2:0]        r_bank;
  logic              r_op_done;
  logic              r_conflict;
  logic              w_serve;

  // Engine requests gathered into arrays indexed by priority slot.
  logic [ADDR_W-1:0]  w_e_addr  [NUM_ENG];
  logic [DATA_W-1:0]  w_e_wdata [NUM_ENG];
  logic [2:0]         w_e_sel   [NUM_ENG];
  logic [NUM_ENG-1:0] w_e_rd;
  logic [NUM_ENG-1:0] w_e_wr;
  logic [NUM_ENG-1:0] w_e_req;
  logic [NUM_ENG-1:0] w_e_grant;
  logic               w_collide;

  assign w_e_addr[ENG_FWD]  = f_addr;
  assign w_e_addr[ENG_BWD]  = b_addr;
  assign w_e_addr[ENG_THR]  = t_addr;
  assign w_e_addr[ENG_CNV]  = c_addr;
  assign w_e_wdata[ENG_FWD] = f_wdata;
  assign w_e_wdata[ENG_BWD] = b_wdata;
  assign w_e_wdata[ENG_THR] = {{(DATA_W-1){1'b0}}, t_wdata};
  assign w_e_wdata[ENG_CNV] = c_wdata;
  assign w_e_sel[ENG_FWD]   = f_sel;
  assign w_e_sel[ENG_BWD]   = b_sel;
  assign w_e_sel[ENG_THR]   = t_sel;
  assign w_e_sel[ENG_CNV]   = c_sel;
  assign w_e_rd = {c_rd, t_rd, b_rd, f_rd};
  assign w_e_wr = {c_wr, t_wr, b_wr, f_wr};

  assign w_serve = (r_state == ST_SERVE);

  // Bank ports
  logic [ADDR_W-1:0] w_bk_addr  [NUM_BANKS];
  logic [DATA_W-1:0] w_bk_wdata [NUM_BANKS];
  logic [DATA_W-1:0] w_bk_rdata [NUM_BANKS];
  logic              w_bk_we    [NUM_BANKS];
  logic              w_bk_re    [NUM_BANKS];
  logic [DATA_W-1:0] w_host_rdata;

  // ------------------------------------------------------------------
  // Arbitration: an engine claims its bank only in SERVE with a strobe and
  // a real bank. It is granted unless a higher-priority engine claims the
  // same bank in the same cycle.
  // ------------------------------------------------------------------
  always_comb begin
    w_e_req   = '0;
    w_e_grant = '0;
    for (int e = 0; e < NUM_ENG; e++) begin
      w_e_req[e] = w_serve && (w_e_rd[e] || w_e_wr[e]) &&
                   sel_in_range(w_e_sel[e], NUM_BANKS);
    end
    for (int e = 0; e < NUM_ENG; e++) begin
      w_e_grant[e] = w_e_req[e];
      for (int j = 0; j < NUM_ENG; j++) begin
        if (j < e && w_e_req[j] && (w_e_sel[j] == w_e_sel[e])) w_e_grant[e] = 1'b0;
      end
    end
  end

  assign w_collide = |(w_e_req & ~w_e_grant);

  // ------------------------------------------------------------------
  // Bank port mux: the host path owns the bank in LOAD/DUMP_RD, the
  // granted engine owns it in SERVE. At most one engine is granted per
  // bank, so loop order does not matter.
  // ------------------------------------------------------------------
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bk_addr[b]  = '0;
      w_bk_wdata[b] = '0;
      w_bk_we[b]    = 1'b0;
      w_bk_re[b]    = 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (load_valid && sel_is(r_bank, b)) begin
            w_bk_we[b]    = 1'b1;
            w_bk_addr[b]  = r_cnt;
            w_bk_wdata[b] = load_data;
          end
        end
        ST_DUMP_RD: begin
          if (sel_is(r_bank, b)) begin
            w_bk_re[b]   = 1'b1;
            w_bk_addr[b] = r_cnt;
          end
        end
        ST_SERVE: begin
          for (int e = 0; e < NUM_ENG; e++) begin
            if (w_e_grant[e] && sel_is(w_e_sel[e], b)) begin
              w_bk_addr[b]  = w_e_addr[e];
              w_bk_wdata[b] = w_e_wdata[e];
              w_bk_we[b]    = w_e_wr[e];
              w_bk_re[b]    = w_e_rd[e];
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    ram_bank #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_bk_we[g]),
      .i_re    (w_bk_re[g]),
      .i_addr  (w_bk_addr[g]),
      .i_wdata (w_bk_wdata[g]),
      .o_rdata (w_bk_rdata[g])
    );
  end

  // Host-side view of the bank chosen by cmd_bank (0 for a missing bank).
  always_comb begin
    w_host_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (sel_is(r_bank, b)) w_host_rdata = w_bk_rdata[b];
    end
  end

  // ------------------------------------------------------------------
  // Engine read return. The bank registers the word at the request edge;
  // the engine's own register takes it one edge later, so the value
  // survives later reads of that bank by other engines. Dropped reads
  // (lost arbitration or no bank) return 0.
  // ------------------------------------------------------------------
  logic [NUM_ENG-1:0] r_pend;
  logic [NUM_ENG-1:0] r_pend_drop;
  logic [2:0]         r_pend_sel [NUM_ENG];
  logic [DATA_W-1:0]  r_e_rdata  [NUM_ENG];
  logic [DATA_W-1:0]  w_pend_data [NUM_ENG];

  always_comb begin
    for (int e = 0; e < NUM_ENG; e++) begin
      w_pend_data[e] = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (sel_is(r_pend_sel[e], b)) w_pend_data[e] = w_bk_rdata[b];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend      <= '0;
      r_pend_drop <= '0;
      for (int e = 0; e < NUM_ENG; e++) begin
        r_pend_sel[e] <= '0;
        r_e_rdata[e]  <= '0;
      end
    end else if (!w_serve) begin
      r_pend      <= '0;
      r_pend_drop <= '0;
      for (int e = 0; e < NUM_ENG; e++) begin
        r_pend_sel[e] <= '0;
        r_e_rdata[e]  <= '0;
      end
    end else begin
      for (int e = 0; e < NUM_ENG; e++) begin
        if (r_pend[e]) r_e_rdata[e] <= r_pend_drop[e] ? '0 : w_pend_data[e];
        r_pend[e]      <= w_e_rd[e];
        r_pend_drop[e] <= ~w_e_grant[e];
        r_pend_sel[e]  <= w_e_sel[e];
      end
    end
  end

  assign f_rdata = w_serve ? r_e_rdata[ENG_FWD] : '0;
  assign b_rdata = w_serve ? r_e_rdata[ENG_BWD] : '0;
  assign t_rdata = w_serve ? r_e_rdata[ENG_THR] : '0;
  assign c_rdata = w_serve ? r_e_rdata[ENG_CNV] : '0;

  // ------------------------------------------------------------------
  // Sequencer FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; w_op_end marks the cycle that finishes an operation.
  always_comb begin
    w_next   = r_state;
    w_op_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_load)       w_next = ST_LOAD;
        else if (start_serve) w_next = ST_SERVE;
        else if (start_dump)  w_next = ST_DUMP_RD;
      end
      ST_LOAD: begin
        if (load_valid && (&r_cnt)) begin
          w_next   = ST_IDLE;
          w_op_end = 1'b1;
        end
      end
      ST_SERVE: begin
        if (serve_end) begin
          w_next   = ST_IDLE;
          w_op_end = 1'b1;
        end
      end
      ST_DUMP_RD: w_next = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (dump_ready) begin
          if (&r_cnt) begin
            w_next   = ST_IDLE;
            w_op_end = 1'b1;
          end else begin
            w_next = ST_DUMP_RD;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    load_ready = (r_state == ST_LOAD);
    dump_valid = (r_state == ST_DUMP_OUT);
    dump_data  = (r_state == ST_DUMP_OUT) ? w_host_rdata : '0;
    busy       = (r_state != ST_IDLE);
  end

  // ------------------------------------------------------------------
  // Counter, latched command bank, done pulse and sticky conflict.
  // op_done is registered so it lines up with the first IDLE cycle,
  // i.e. the cycle busy drops.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_bank     <= '0;
      r_op_done  <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_op_done  <= w_op_end;
      r_conflict <= r_conflict | w_collide;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_next == ST_LOAD || w_next == ST_DUMP_RD) r_bank <= cmd_bank;
        end
        ST_LOAD:     if (load_valid) r_cnt <= r_cnt + 1'b1;
        ST_DUMP_OUT: if (dump_ready) r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign op_done     = r_op_done;
  assign conflict    = r_conflict;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_image_ram_hub.sv
module tb_image_ram_hub;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int NB    = 5;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT signals ----------------
  logic [AW-1:0] f_addr, b_addr, t_addr, c_addr;
  logic          f_rd, b_rd, t_rd, c_rd, f_wr, b_wr, t_wr, c_wr;
  logic [DW-1:0] f_wdata, b_wdata, c_wdata;
  logic          t_wdata;
  logic [2:0]    f_sel, b_sel, t_sel, c_sel;
  logic [DW-1:0] f_rdata, b_rdata, t_rdata, c_rdata;
  logic          conflict;
  logic          start_load, start_serve, start_dump, serve_end;
  logic [2:0]    cmd_bank;
  logic          load_valid, load_ready, dump_valid, dump_ready, busy, op_done;
  logic [DW-1:0] load_data, dump_data;
  logic [2:0]    o_dbg_state;

  // Engine drive arrays, slot 0..3 = forward, backward, threshold, convolution
  logic [AW-1:0] e_addr  [4];
  logic          e_rd    [4];
  logic          e_wr    [4];
  logic [DW-1:0] e_wdata [4];
  logic [2:0]    e_sel   [4];
  logic [DW-1:0] rdata_o [4];

  assign f_addr = e_addr[0];  assign b_addr = e_addr[1];
  assign t_addr = e_addr[2];  assign c_addr = e_addr[3];
  assign f_rd = e_rd[0];  assign b_rd = e_rd[1];  assign t_rd = e_rd[2];  assign c_rd = e_rd[3];
  assign f_wr = e_wr[0];  assign b_wr = e_wr[1];  assign t_wr = e_wr[2];  assign c_wr = e_wr[3];
  assign f_wdata = e_wdata[0];  assign b_wdata = e_wdata[1];
  assign t_wdata = e_wdata[2][0];  assign c_wdata = e_wdata[3];
  assign f_sel = e_sel[0];  assign b_sel = e_sel[1];  assign t_sel = e_sel[2];  assign c_sel = e_sel[3];
  assign rdata_o[0] = f_rdata;  assign rdata_o[1] = b_rdata;
  assign rdata_o[2] = t_rdata;  assign rdata_o[3] = c_rdata;

  image_ram_hub #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(NB)) dut (
    .clk(clk), .reset(reset),
    .f_addr(f_addr), .b_addr(b_addr), .t_addr(t_addr), .c_addr(c_addr),
    .f_rd(f_rd), .b_rd(b_rd), .t_rd(t_rd), .c_rd(c_rd),
    .f_wr(f_wr), .b_wr(b_wr), .t_wr(t_wr), .c_wr(c_wr),
    .f_wdata(f_wdata), .b_wdata(b_wdata), .t_wdata(t_wdata), .c_wdata(c_wdata),
    .f_sel(f_sel), .b_sel(b_sel), .t_sel(t_sel), .c_sel(c_sel),
    .f_rdata(f_rdata), .b_rdata(b_rdata), .t_rdata(t_rdata), .c_rdata(c_rdata),
    .conflict(conflict),
    .start_load(start_load), .start_serve(start_serve), .start_dump(start_dump),
    .cmd_bank(cmd_bank), .serve_end(serve_end),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
    .busy(busy), .op_done(op_done), .o_dbg_state(o_dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mem  [NB][DEPTH];  // expected bank contents
  logic [DW-1:0] vis  [4];          // rdata each engine should show now
  logic [DW-1:0] pval [4];          // read result in flight
  bit            pv   [4];
  bit            conf_exp = 0;
  logic [DW-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_engines();
    for (int e = 0; e < 4; e++) begin
      e_addr[e] = '0; e_rd[e] = 0; e_wr[e] = 0; e_wdata[e] = '0; e_sel[e] = '0;
    end
  endtask

  task automatic set_eng(input int e, input bit rd, input bit wr, input logic [2:0] sel,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    e_rd[e] = rd; e_wr[e] = wr; e_sel[e] = sel; e_addr[e] = addr; e_wdata[e] = wd;
  endtask

  // One SERVE cycle: resolve requests by priority on the model memory, then
  // advance one clock. A read becomes visible one cycle after its edge.
  task automatic serve_step();
    bit            taken [NB];
    bit            npv   [4];
    logic [DW-1:0] nval  [4];
    logic [DW-1:0] wd;
    int            s;
    for (int b = 0; b < NB; b++) taken[b] = 0;
    for (int e = 0; e < 4; e++) begin
      npv[e]  = e_rd[e];
      nval[e] = '0;
      s = int'(e_sel[e]);
      if ((e_rd[e] || e_wr[e]) && s < NB) begin
        if (taken[s]) conf_exp = 1;
        else begin
          taken[s] = 1;
          if (e_rd[e]) nval[e] = mem[s][e_addr[e]];
          wd = (e == 2) ? {7'd0, e_wdata[2][0]} : e_wdata[e];
          if (e_wr[e]) mem[s][e_addr[e]] = wd;
        end
      end
    end
    tick();
    for (int e = 0; e < 4; e++) begin
      if (pv[e]) vis[e] = pval[e];
      pv[e]   = npv[e];
      pval[e] = nval[e];
    end
  endtask

  task automatic begin_serve();
    start_serve = 1; tick(); start_serve = 0;
    for (int e = 0; e < 4; e++) begin vis[e] = '0; pv[e] = 0; pval[e] = '0; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({f_rdata, b_rdata, t_rdata, c_rdata} !== '0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0", {f_rdata, b_rdata, t_rdata, c_rdata});
    end
    total++;
    if ({conflict, load_ready, dump_valid, dump_data, busy, op_done, o_dbg_state} !== '0) begin
      bad++; $display("FAIL reset_ctrl got=%h exp=0",
                      {conflict, load_ready, dump_valid, dump_data, busy, op_done, o_dbg_state});
    end
    reset = 1;
    tick();
  endtask

  task automatic test_load(input logic [2:0] bank, input bit gaps, input bit seq);
    logic [DW-1:0] d;
    int i = 0;
    int cyc = 0;
    start_load = 1; cmd_bank = bank; tick(); start_load = 0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL load_busy_rise got=%b exp=1", busy); end
    while (i < DEPTH && cyc < 200) begin
      load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = seq ? DW'(i) : DW'($urandom);
      load_data = d;
      total++;
      if (load_ready !== 1'b1 || op_done !== 1'b0) begin
        bad++; $display("FAIL load_ready word=%0d got=%b/%b exp=1/0", i, load_ready, op_done);
      end
      @(posedge clk);
      if (load_valid) begin mem[bank][i] = d; i++; end
      @(negedge clk);
      cyc++;
    end
    load_valid = 0;
    if (i < DEPTH) begin total++; bad++; $display("FAIL load_timeout got=%0d exp=%0d", i, DEPTH); end
    total++;
    if (op_done !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b0) begin
      bad++; $display("FAIL load_done got=%b%b%b exp=100", op_done, busy, load_ready);
    end
    if (!gaps) begin
      total++;
      if (cyc != DEPTH) begin bad++; $display("FAIL load_cycles got=%0d exp=%0d", cyc, DEPTH); end
    end
    tick();
    total++;
    if (op_done !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%b exp=0", op_done); end
  endtask

  task automatic test_dump(input logic [2:0] bank, input bit toggle);
    int cyc = 0;
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(mem[bank][k]);
    start_dump = 1; cmd_bank = bank; tick(); start_dump = 0;
    while (exp_q.size() > 0 && cyc < 300) begin
      dump_ready = toggle ? cyc[1] : 1'($urandom_range(0, 1));
      if (dump_valid) begin
        total++;
        if (dump_data !== exp_q[0] || op_done !== 1'b0) begin
          bad++; $display("FAIL dump_word left=%0d got=%h exp=%h", exp_q.size(), dump_data, exp_q[0]);
        end
        if (dump_ready) void'(exp_q.pop_front());
      end
      tick();
      cyc++;
    end
    dump_ready = 0;
    if (exp_q.size() > 0) begin
      total++; bad++; $display("FAIL dump_timeout got=%0d exp=0 words left", exp_q.size());
    end
    total++;
    if (op_done !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0 || dump_data !== '0) begin
      bad++; $display("FAIL dump_done got=%b%b%b %h exp=100 00", op_done, busy, dump_valid, dump_data);
    end
    tick();
  endtask

  task automatic test_idle_engines();
    set_eng(0, 1, 0, 3'd0, 4'd5, 8'h00);
    set_eng(1, 0, 1, 3'd0, 4'd1, 8'hFF);   // must not land outside SERVE
    tick(); tick();
    total++;
    if ({f_rdata, b_rdata, t_rdata, c_rdata} !== '0) begin
      bad++; $display("FAIL idle_rdata got=%h exp=0", {f_rdata, b_rdata, t_rdata, c_rdata});
    end
    clear_engines();
    tick();
  endtask

  task automatic test_serve_basic();
    begin_serve();
    set_eng(0, 1, 0, 3'd0, 4'd5, 8'h00);
    serve_step();
    clear_engines();
    total++;
    if (f_rdata !== vis[0]) begin bad++; $display("FAIL serve_latency got=%h exp=%h", f_rdata, vis[0]); end
    serve_step();
    total++;
    if (f_rdata !== 8'd5 || f_rdata !== vis[0]) begin
      bad++; $display("FAIL serve_f_read got=%h exp=05", f_rdata);
    end
    set_eng(2, 0, 1, 3'd2, 4'd3, 8'hFF);      // only bit 0 is carried
    serve_step();
    clear_engines();
    set_eng(3, 1, 0, 3'd2, 4'd3, 8'h00);
    serve_step();
    clear_engines();
    serve_step();
    total++;
    if (c_rdata !== 8'h01) begin bad++; $display("FAIL serve_thr_write got=%h exp=01", c_rdata); end
    // read and write in one cycle returns the old word
    set_eng(0, 1, 1, 3'd0, 4'd2, 8'h77);
    serve_step();
    set_eng(0, 1, 0, 3'd0, 4'd2, 8'h00);
    serve_step();
    total++;
    if (f_rdata !== 8'd2 || f_rdata !== vis[0]) begin
      bad++; $display("FAIL serve_rbw_old got=%h exp=02", f_rdata);
    end
    clear_engines();
    serve_step();
    total++;
    if (f_rdata !== 8'h77) begin bad++; $display("FAIL serve_rbw_new got=%h exp=77", f_rdata); end
    // out-of-range select
    set_eng(0, 1, 1, 3'd7, 4'd0, 8'h33);
    set_eng(1, 1, 1, 3'd7, 4'd0, 8'h44);
    serve_step();
    clear_engines();
    serve_step();
    total++;
    if (f_rdata !== 8'h00 || conflict !== 1'b0) begin
      bad++; $display("FAIL serve_bad_sel got=%h/%b exp=00/0", f_rdata, conflict);
    end
    serve_end = 1; tick(); serve_end = 0;
    total++;
    if (op_done !== 1'b1 || busy !== 1'b0 || {f_rdata, b_rdata, t_rdata, c_rdata} !== '0) begin
      bad++; $display("FAIL serve_end got=%b%b %h exp=10 0", op_done, busy, {f_rdata, b_rdata, t_rdata, c_rdata});
    end
    tick();
  endtask

  task automatic test_collision();
    begin_serve();
    set_eng(0, 0, 1, 3'd1, 4'd0, 8'hAA);
    set_eng(1, 0, 1, 3'd1, 4'd0, 8'h55);
    serve_step();
    total++;
    if (conflict !== 1'b1 || conflict !== conf_exp) begin
      bad++; $display("FAIL coll_flag got=%b exp=1", conflict);
    end
    set_eng(0, 1, 0, 3'd1, 4'd0, 8'h00);
    set_eng(1, 1, 0, 3'd1, 4'd0, 8'h00);
    serve_step();
    clear_engines();
    serve_step();
    total++;
    if (f_rdata !== 8'hAA || b_rdata !== 8'h00) begin
      bad++; $display("FAIL coll_data got=%h/%h exp=aa/00", f_rdata, b_rdata);
    end
    serve_end = 1; tick(); serve_end = 0;
    total++;
    if (conflict !== 1'b1 || op_done !== 1'b1) begin
      bad++; $display("FAIL coll_sticky got=%b/%b exp=1/1", conflict, op_done);
    end
    tick();
  endtask

  task automatic test_serve_random();
    begin_serve();
    for (int n = 0; n < 300; n++) begin
      for (int e = 0; e < 4; e++) begin
        set_eng(e, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7)),
                AW'($urandom_range(0, 7)), DW'($urandom));
      end
      serve_step();
      for (int e = 0; e < 4; e++) begin
        total++;
        if (rdata_o[e] !== vis[e]) begin
          bad++; $display("FAIL rand_rdata cyc=%0d eng=%0d got=%h exp=%h", n, e, rdata_o[e], vis[e]);
        end
      end
      total++;
      if (conflict !== conf_exp) begin
        bad++; $display("FAIL rand_conflict cyc=%0d got=%b exp=%b", n, conflict, conf_exp);
      end
    end
    clear_engines();
    serve_end = 1; tick(); serve_end = 0;
    tick();
  endtask

  task automatic test_start_priority();
    logic [DW-1:0] d;
    int i = 0;
    int cyc = 0;
    start_load = 1; start_serve = 1; start_dump = 1; cmd_bank = 3'd4;
    tick();
    start_load = 0; start_serve = 0;
    total++;
    if (load_ready !== 1'b1 || dump_valid !== 1'b0) begin
      bad++; $display("FAIL start_prio got=%b%b exp=10", load_ready, dump_valid);
    end
    while (i < DEPTH && cyc < 100) begin
      if (i == 8) start_dump = 0;   // held starts are ignored while busy
      load_valid = 1; d = DW'($urandom); load_data = d;
      @(posedge clk); mem[4][i] = d; i++; @(negedge clk);
      cyc++;
    end
    load_valid = 0;
    total++;
    if (op_done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL start_prio_done got=%b%b exp=10", op_done, busy);
    end
    tick();
    test_dump(3'd4, 0);
  endtask

  task automatic test_reset_mid_load();
    logic [DW-1:0] d;
    start_load = 1; cmd_bank = 3'd3; tick(); start_load = 0;
    for (int i = 0; i < 7; i++) begin
      load_valid = 1; d = DW'($urandom); load_data = d;
      @(posedge clk); mem[3][i] = d; @(negedge clk);
    end
    load_valid = 0;
    reset = 0;
    conf_exp = 0;
    #1;
    total++;
    if ({conflict, load_ready, dump_valid, dump_data, busy, op_done, f_rdata} !== '0) begin
      bad++; $display("FAIL midreset got=%h exp=0",
                      {conflict, load_ready, dump_valid, dump_data, busy, op_done, f_rdata});
    end
    @(negedge clk);
    reset = 1;
    tick();
    test_load(3'd3, 0, 0);
    test_dump(3'd3, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 0;
    start_load = 0; start_serve = 0; start_dump = 0; serve_end = 0;
    cmd_bank = '0; load_valid = 0; load_data = '0; dump_ready = 0;
    clear_engines();
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < DEPTH; k++) mem[b][k] = '0;
    test_reset();
    test_load(3'd0, 0, 1);
    test_load(3'd1, 1, 0);
    test_load(3'd2, 1, 0);
    test_idle_engines();
    test_serve_basic();
    test_collision();
    test_serve_random();
    test_dump(3'd0, 1);
    test_dump(3'd1, 0);
    test_dump(3'd2, 0);
    test_start_priority();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
